// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: datapath widths, opcodes
// and the MEM-stage access FSM encoding.
package cpu16_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_BUSY = 1'b1
  } mem_state_t;
endpackage

// File: rtl/data_mem.sv
// Word-organised data memory: asynchronous read, write on the falling clock
// edge, contents survive reset.
module data_mem
  import cpu16_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(negedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// Memory/writeback stage: EX/MEM and MEM/WB registers, multi-cycle data memory
// access with upstream stall, MemtoReg mux and forwarding taps.
module mem_stage
  import cpu16_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_wr,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  output logic              stall,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_wr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              wb_regwrite,
  output logic [REG_AW-1:0] wb_wr,
  output logic [DATA_W-1:0] wb_wd,
  output logic              mem_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  logic              vld_p0, rw_p0, m2r_p0, rd_p0, wm_p0;
  logic [DATA_W-1:0] alu_p0, sd_p0;
  logic [REG_AW-1:0] wr_p0;

  mem_state_t        state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              mem_op, misaligned, acc_done, we, bad_op, wb_en_nx;
  logic [DATA_W-1:0] rdata, wd_nx;

  // ---- EX/MEM boundary: control bits reset, payload just follows the stall
  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p0 <= 1'b0;
      rw_p0  <= 1'b0;
      m2r_p0 <= 1'b0;
      rd_p0  <= 1'b0;
      wm_p0  <= 1'b0;
    end else if (!stall) begin
      vld_p0 <= ex_valid;
      rw_p0  <= ex_regwrite;
      m2r_p0 <= ex_memtoreg;
      rd_p0  <= ex_memread;
      wm_p0  <= ex_memwrite;
    end
  end

  always_ff @(negedge clock) begin
    if (!stall) begin
      alu_p0 <= ex_alu_out;
      sd_p0  <= ex_store_data;
      wr_p0  <= ex_wr;
    end
  end

  assign mem_op     = vld_p0 && (rd_p0 || wm_p0);
  assign misaligned = alu_p0[0];
  assign acc_done   = (MEM_LAT == 0) || ((state == MS_BUSY) && (cnt == LAST));
  assign stall      = mem_op && (MEM_LAT != 0) && !acc_done;
  assign we         = mem_op && wm_p0 && !misaligned && !stall;
  assign bad_op     = mem_op && (misaligned || (rd_p0 && wm_p0));

  assign fwd_valid = vld_p0 && rw_p0 && !rd_p0 && (wr_p0 != '0);
  assign fwd_wr    = wr_p0;
  assign fwd_data  = alu_p0;

  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= MS_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      MS_IDLE: begin
        if (mem_op && (MEM_LAT != 0)) begin
          state_nx = MS_BUSY;
          cnt_nx   = '0;
        end
      end
      MS_BUSY: begin
        if (acc_done) begin
          state_nx = MS_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = MS_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Word index drops the byte bit; upper address bits wrap away.
  data_mem #(.DEPTH(DEPTH), .AW(AW)) u_data_mem (
    .clock (clock),
    .we    (we),
    .addr  (alu_p0[AW:1]),
    .wdata (sd_p0),
    .rdata (rdata)
  );

  // Misaligned ops and read+write combos complete as bubbles.
  assign wb_en_nx = vld_p0 && rw_p0 && !(mem_op && misaligned)
                    && !(rd_p0 && wm_p0) && (wr_p0 != '0);
  assign wd_nx    = m2r_p0 ? rdata : alu_p0;

  // ---- MEM/WB boundary
  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      wb_regwrite <= 1'b0;
      wb_wr       <= '0;
      wb_wd       <= '0;
      mem_err     <= 1'b0;
    end else begin
      if (stall) begin
        wb_regwrite <= 1'b0;
      end else begin
        wb_regwrite <= wb_en_nx;
        if (wb_en_nx) begin
          wb_wr <= wr_p0;
          wb_wd <= wd_nx;
        end
        if (bad_op) mem_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage (DEPTH=256, MEM_LAT=2): directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_stage;
  localparam int LAT = 2;
  localparam int DEP = 256;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_valid = 1'b0;
  logic [15:0] ex_alu_out = '0;
  logic [15:0] ex_store_data = '0;
  logic [1:0]  ex_wr = '0;
  logic        ex_regwrite = 1'b0, ex_memtoreg = 1'b0, ex_memread = 1'b0, ex_memwrite = 1'b0;
  logic        stall, fwd_valid, wb_regwrite, mem_err;
  logic [1:0]  fwd_wr, wb_wr;
  logic [15:0] fwd_data, wb_wd;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.DEPTH(DEP), .MEM_LAT(LAT)) dut (
    .clock(clock), .resetn(resetn), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_wr(ex_wr), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .stall(stall), .fwd_valid(fwd_valid), .fwd_wr(fwd_wr), .fwd_data(fwd_data),
    .wb_regwrite(wb_regwrite), .wb_wr(wb_wr), .wb_wd(wb_wd), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  // State updates happen on negedge; inputs are driven and outputs sampled
  // just after the posedge.
  task automatic tick;
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [1:0] wr, input logic rw, input logic m2r,
                       input logic rd, input logic wm);
    ex_valid = v; ex_alu_out = alu; ex_store_data = sd; ex_wr = wr;
    ex_regwrite = rw; ex_memtoreg = m2r; ex_memread = rd; ex_memwrite = wm;
  endtask

  task automatic bubble;
    drive(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Issue one memory op and advance to the point where its result is visible.
  task automatic mem_run(input logic [15:0] alu, input logic [15:0] sd, input logic [1:0] wr,
                         input logic rw, input logic m2r, input logic rd, input logic wm);
    drive(1'b1, alu, sd, wr, rw, m2r, rd, wm);
    tick;
    bubble;
    for (int i = 0; i <= LAT; i++) tick;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bubble;
    #3;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_vec++; if (fwd_valid !== 1'b0) begin n_err++; $display("FAIL reset_fwd_valid: got %b want 0", fwd_valid); end
    n_vec++; if (wb_regwrite !== 1'b0) begin n_err++; $display("FAIL reset_wb_regwrite: got %b want 0", wb_regwrite); end
    n_vec++; if (wb_wr !== 2'd0) begin n_err++; $display("FAIL reset_wb_wr: got %0d want 0", wb_wr); end
    n_vec++; if (wb_wd !== 16'h0) begin n_err++; $display("FAIL reset_wb_wd: got %h want 0000", wb_wd); end
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
    @(posedge clock); #1;
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_alu;
    drive(1'b1, 16'd22, 16'h0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    n_vec++; if (fwd_valid !== 1'b1) begin n_err++; $display("FAIL alu_fwd_valid: got %b want 1", fwd_valid); end
    n_vec++; if (fwd_data !== 16'd22) begin n_err++; $display("FAIL alu_fwd_data: got %0d want 22", fwd_data); end
    n_vec++; if (fwd_wr !== 2'd3) begin n_err++; $display("FAIL alu_fwd_wr: got %0d want 3", fwd_wr); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b want 0", stall); end
    n_vec++; if (wb_regwrite !== 1'b0) begin n_err++; $display("FAIL alu_wb_early: got %b want 0", wb_regwrite); end
    bubble;
    tick;
    n_vec++; if (wb_regwrite !== 1'b1) begin n_err++; $display("FAIL alu_wb_regwrite: got %b want 1", wb_regwrite); end
    n_vec++; if (wb_wr !== 2'd3) begin n_err++; $display("FAIL alu_wb_wr: got %0d want 3", wb_wr); end
    n_vec++; if (wb_wd !== 16'd22) begin n_err++; $display("FAIL alu_wb_wd: got %0d want 22", wb_wd); end
    tick;
    n_vec++; if (wb_regwrite !== 1'b0) begin n_err++; $display("FAIL alu_wb_after: got %b want 0", wb_regwrite); end
    n_vec++; if (wb_wd !== 16'd22) begin n_err++; $display("FAIL alu_wb_hold: got %0d want 22", wb_wd); end
  endtask

  task automatic test_sw_lw;
    drive(1'b1, 16'h0010, 16'h1234, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL sw_stall1: got %b want 1", stall); end
    bubble;
    tick;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL sw_stall2: got %b want 1", stall); end
    n_vec++; if (wb_regwrite !== 1'b0) begin n_err++; $display("FAIL sw_bubble: got %b want 0", wb_regwrite); end
    tick;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL sw_stall_end: got %b want 0", stall); end
    drive(1'b1, 16'h0010, 16'h0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lw_stall1: got %b want 1", stall); end
    n_vec++; if (fwd_valid !== 1'b0) begin n_err++; $display("FAIL lw_no_fwd: got %b want 0", fwd_valid); end
    bubble;
    tick;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lw_stall2: got %b want 1", stall); end
    n_vec++; if (wb_regwrite !== 1'b0) begin n_err++; $display("FAIL lw_bubble: got %b want 0", wb_regwrite); end
    tick;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lw_stall_end: got %b want 0", stall); end
    n_vec++; if (wb_regwrite !== 1'b0) begin n_err++; $display("FAIL lw_early: got %b want 0", wb_regwrite); end
    tick;
    n_vec++; if (wb_regwrite !== 1'b1) begin n_err++; $display("FAIL lw_wb_regwrite: got %b want 1", wb_regwrite); end
    n_vec++; if (wb_wr !== 2'd1) begin n_err++; $display("FAIL lw_wb_wr: got %0d want 1", wb_wr); end
    n_vec++; if (wb_wd !== 16'h1234) begin n_err++; $display("FAIL lw_wb_wd: got %h want 1234", wb_wd); end
  endtask

  task automatic test_reg0;
    drive(1'b1, 16'd15, 16'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    n_vec++; if (fwd_valid !== 1'b0) begin n_err++; $display("FAIL reg0_fwd: got %b want 0", fwd_valid); end
    bubble;
    tick;
    n_vec++; if (wb_regwrite !== 1'b0) begin n_err++; $display("FAIL reg0_wb: got %b want 0", wb_regwrite); end
  endtask

  task automatic test_wrap;
    mem_run(16'h0202, 16'h00AA, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    mem_run(16'h0002, 16'h0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++; if (wb_regwrite !== 1'b1) begin n_err++; $display("FAIL wrap_wb_regwrite: got %b want 1", wb_regwrite); end
    n_vec++; if (wb_wd !== 16'h00AA) begin n_err++; $display("FAIL wrap_wb_wd: got %h want 00aa", wb_wd); end
    n_vec++; if (wb_wr !== 2'd2) begin n_err++; $display("FAIL wrap_wb_wr: got %0d want 2", wb_wr); end
  endtask

  task automatic test_misaligned;
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL mis_err_before: got %b want 0", mem_err); end
    mem_run(16'h0011, 16'h0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL mis_err_set: got %b want 1", mem_err); end
    n_vec++; if (wb_regwrite !== 1'b0) begin n_err++; $display("FAIL mis_lw_wb: got %b want 0", wb_regwrite); end
    mem_run(16'h0011, 16'hDEAD, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    mem_run(16'h0010, 16'h0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++; if (wb_wd !== 16'h1234) begin n_err++; $display("FAIL mis_mem_unchanged: got %h want 1234", wb_wd); end
    // read and write together: behaves as a store, no register write
    mem_run(16'h0020, 16'h7777, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_vec++; if (wb_regwrite !== 1'b0) begin n_err++; $display("FAIL rdwr_wb: got %b want 0", wb_regwrite); end
    mem_run(16'h0020, 16'h0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++; if (wb_wd !== 16'h7777) begin n_err++; $display("FAIL rdwr_stored: got %h want 7777", wb_wd); end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(i * 3), 16'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick;
      n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL mis_err_sticky%0d: got %b want 1", i, mem_err); end
    end
    bubble;
    tick;
  endtask

  task automatic test_reset_mid;
    mem_run(16'h0004, 16'hBEEF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'h0004, 16'h5555, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rmid_stall_pre: got %b want 1", stall); end
    resetn = 1'b0;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rmid_stall: got %b want 0", stall); end
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rmid_mem_err: got %b want 0", mem_err); end
    n_vec++; if (wb_wr !== 2'd0) begin n_err++; $display("FAIL rmid_wb_wr: got %0d want 0", wb_wr); end
    n_vec++; if (wb_wd !== 16'h0) begin n_err++; $display("FAIL rmid_wb_wd: got %h want 0000", wb_wd); end
    n_vec++; if (fwd_valid !== 1'b0) begin n_err++; $display("FAIL rmid_fwd: got %b want 0", fwd_valid); end
    bubble;
    tick;
    resetn = 1'b1;
    tick;
    mem_run(16'h0004, 16'h0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++; if (wb_wd !== 16'hBEEF) begin n_err++; $display("FAIL rmid_mem_kept: got %h want beef", wb_wd); end
  endtask

  typedef struct {
    logic        v;
    logic [15:0] alu, sd;
    logic [1:0]  wr;
    logic        rw, m2r, rd, wm;
  } op_t;

  typedef struct {
    int          due;
    logic        en;
    logic [1:0]  wr;
    logic [15:0] wd;
  } res_t;

  // Transaction model: ops are serialised, a memory op occupies the stage for
  // LAT+1 cycles, every op's writeback is due one cycle after it finishes.
  task automatic test_random;
    logic [15:0] mm [DEP];
    bit          known [DEP];
    res_t        pend [$];
    op_t         cur, nxt;
    int          busy_last;
    bit          have_last;
    logic [1:0]  last_wr;
    logic [15:0] last_wd;
    logic        st_exp, en_exp, fwd_exp;
    logic [6:0]  hi;
    logic [7:0]  idx;
    int          k;

    for (int i = 0; i < DEP; i++) known[i] = 1'b0;
    bubble;
    tick;
    tick;
    cur = '{v: 1'b0, alu: 16'h0, sd: 16'h0, wr: 2'd0, rw: 1'b0, m2r: 1'b0, rd: 1'b0, wm: 1'b0};
    nxt = cur;
    busy_last = -1;
    have_last = 1'b0;
    last_wr = '0;
    last_wd = '0;

    for (int e = 0; e < 600; e++) begin
      st_exp = (e <= busy_last);
      en_exp = 1'b0;
      if (pend.size() > 0 && pend[0].due == e) begin
        en_exp = pend[0].en;
        if (pend[0].en) begin
          have_last = 1'b1;
          last_wr = pend[0].wr;
          last_wd = pend[0].wd;
        end
        void'(pend.pop_front());
      end
      fwd_exp = cur.v && cur.rw && !cur.rd && (cur.wr != 2'd0);
      n_vec++; if (stall !== st_exp) begin n_err++; $display("FAIL rnd_stall@%0d: got %b want %b", e, stall, st_exp); end
      n_vec++; if (wb_regwrite !== en_exp) begin n_err++; $display("FAIL rnd_wb_regwrite@%0d: got %b want %b", e, wb_regwrite, en_exp); end
      if (have_last) begin
        n_vec++; if (wb_wr !== last_wr || wb_wd !== last_wd) begin
          n_err++; $display("FAIL rnd_wb_data@%0d: got %0d/%h want %0d/%h", e, wb_wr, wb_wd, last_wr, last_wd);
        end
      end
      n_vec++; if (fwd_valid !== fwd_exp) begin n_err++; $display("FAIL rnd_fwd_valid@%0d: got %b want %b", e, fwd_valid, fwd_exp); end
      if (fwd_exp) begin
        n_vec++; if (fwd_data !== cur.alu || fwd_wr !== cur.wr) begin
          n_err++; $display("FAIL rnd_fwd_data@%0d: got %0d/%h want %0d/%h", e, fwd_wr, fwd_data, cur.wr, cur.alu);
        end
      end
      n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rnd_mem_err@%0d: got %b want 0", e, mem_err); end

      if (!st_exp) begin
        k = $urandom_range(0, 9);
        hi = 7'($urandom_range(0, 127));
        idx = 8'($urandom_range(0, 15));
        nxt.v = (k >= 2);
        nxt.alu = 16'($urandom);
        nxt.sd = 16'($urandom);
        nxt.wr = 2'($urandom_range(0, 3));
        nxt.rw = 1'b1; nxt.m2r = 1'b0; nxt.rd = 1'b0; nxt.wm = 1'b0;
        if (k >= 8 && !known[idx]) k = 6;
        if (k >= 6) nxt.alu = {hi, idx, 1'b0};
        if (k == 6 || k == 7) begin nxt.rw = 1'b0; nxt.wm = 1'b1; end
        if (k >= 8) begin nxt.m2r = 1'b1; nxt.rd = 1'b1; end
        drive(nxt.v, nxt.alu, nxt.sd, nxt.wr, nxt.rw, nxt.m2r, nxt.rd, nxt.wm);
      end
      tick;
      if (!st_exp) begin
        cur = nxt;
        if (cur.v) begin
          res_t r;
          idx = cur.alu[8:1];
          r.en = cur.rw && (cur.wr != 2'd0);
          r.wr = cur.wr;
          r.wd = cur.alu;
          if (cur.rd || cur.wm) begin
            r.due = e + 2 + LAT;
            busy_last = e + 1 + LAT - 1;
            if (cur.wm) begin mm[idx] = cur.sd; known[idx] = 1'b1; end
            else r.wd = mm[idx];
          end else begin
            r.due = e + 2;
          end
          pend.push_back(r);
        end
      end
    end
    bubble;
    tick;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_sw_lw;
    test_reg0;
    test_wrap;
    test_misaligned;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
